psram_arbiter: RTL

- Shares the single byte-wide psram controller between two requesters: the video fetch path (read-only, latency critical) and the command path (host reads/writes).
- Sits between those requesters and the psram controller's i_stb/i_we/i_addr/i_din/o_busy/o_done/o_dout interface, in the 100 MHz domain.
- Video has priority, with a run limit so commands are never starved.
- A timeout converts a missing done into an error-flagged acknowledge.

---
 rtl/psram_arbiter.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/psram_arbiter.sv
// psram_arbiter: shares one byte-wide psram controller between the video fetch
// path (read-only, priority) and the command path (host reads/writes).
//
// Ports
//   i_clk, i_rst                  clock, asynchronous active-high reset
//   i_vid_req/i_vid_addr          video read request, held until o_vid_ack
//   o_vid_ack/o_vid_data          video completion pulse and read byte (held)
//   i_cmd_req/_we/_addr/_din      command request, held until o_cmd_ack
//   o_cmd_ack/o_cmd_data          command completion pulse and read byte (held)
//   o_err                         qualifies an ack whose transfer timed out
//   o_owner                       00 idle, 01 video, 10 command
//   o_stb/o_we/o_addr/o_din       request to the psram controller
//   i_busy/i_done/i_dout          psram controller status and read data
//
// Video wins arbitration until it has taken VID_MAX_RUN grants in a row while a
// command waits; then the command is served. All outputs are registered.
module psram_arbiter #(
  parameter int unsigned AW          = 24,
  parameter int unsigned DW          = 8,
  parameter int unsigned VID_MAX_RUN = 4,
  parameter int unsigned TIMEOUT     = 64
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_vid_req,
  input  logic [AW-1:0] i_vid_addr,
  output logic          o_vid_ack,
  output logic [DW-1:0] o_vid_data,
  input  logic          i_cmd_req,
  input  logic          i_cmd_we,
  input  logic [AW-1:0] i_cmd_addr,
  input  logic [DW-1:0] i_cmd_din,
  output logic          o_cmd_ack,
  output logic [DW-1:0] o_cmd_data,
  output logic          o_err,
  output logic [1:0]    o_owner,
  output logic          o_stb,
  output logic          o_we,
  output logic [AW-1:0] o_addr,
  output logic [DW-1:0] o_din,
  input  logic          i_busy,
  input  logic          i_done,
  input  logic [DW-1:0] i_dout
);

  localparam int unsigned RW = $clog2(VID_MAX_RUN + 1);
  localparam int unsigned TW = $clog2(TIMEOUT);

  localparam logic [1:0] OwnNone = 2'b00;
  localparam logic [1:0] OwnVid  = 2'b01;
  localparam logic [1:0] OwnCmd  = 2'b10;

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

  state_e        state_q, state_d;
  logic [RW-1:0] run_cnt_q, run_cnt_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          stb_q, stb_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] din_q, din_d;
  logic [1:0]    owner_q, owner_d;
  logic          vid_ack_q, vid_ack_d;
  logic          cmd_ack_q, cmd_ack_d;
  logic          err_q, err_d;
  logic [DW-1:0] vid_data_q, vid_data_d;
  logic [DW-1:0] cmd_data_q, cmd_data_d;

  logic grant_vid, grant_cmd;

  // Video wins unless it has exhausted its run while a command waits.
  assign grant_vid = i_vid_req && (!i_cmd_req || (run_cnt_q < RW'(VID_MAX_RUN)));
  assign grant_cmd = i_cmd_req && !grant_vid;

  always_comb begin
    state_d    = state_q;
    run_cnt_d  = run_cnt_q;
    timer_d    = timer_q;
    stb_d      = 1'b0;
    we_d       = we_q;
    addr_d     = addr_q;
    din_d      = din_q;
    owner_d    = owner_q;
    vid_ack_d  = 1'b0;
    cmd_ack_d  = 1'b0;
    err_d      = 1'b0;
    vid_data_d = vid_data_q;
    cmd_data_d = cmd_data_q;

    unique case (state_q)
      StIdle: begin
        if (!i_vid_req) run_cnt_d = '0;
        if (grant_vid) begin
          owner_d = OwnVid;
          addr_d  = i_vid_addr;
          we_d    = 1'b0;
          din_d   = '0;
          if (run_cnt_q < RW'(VID_MAX_RUN)) run_cnt_d = run_cnt_q + RW'(1);
          // Strobe is registered, so the busy check happens one cycle early.
          stb_d   = !i_busy;
          state_d = StIssue;
        end else if (grant_cmd) begin
          owner_d   = OwnCmd;
          addr_d    = i_cmd_addr;
          we_d      = i_cmd_we;
          din_d     = i_cmd_din;
          run_cnt_d = '0;
          stb_d     = !i_busy;
          state_d   = StIssue;
        end
      end

      StIssue: begin
        if (stb_q) begin
          // Strobe is on the bus this cycle; start the completion timer.
          timer_d = '0;
          state_d = StWait;
        end else if (!i_busy) begin
          stb_d = 1'b1;
        end
      end

      StWait: begin
        timer_d = timer_q + TW'(1);
        if (i_done || (timer_q == TW'(TIMEOUT - 1))) begin
          vid_ack_d = (owner_q == OwnVid);
          cmd_ack_d = (owner_q == OwnCmd);
          // Done takes precedence over a coincident timeout.
          err_d     = !i_done;
          if (i_done && (owner_q == OwnVid)) vid_data_d = i_dout;
          if (i_done && (owner_q == OwnCmd) && !we_q) cmd_data_d = i_dout;
          owner_d   = OwnNone;
          we_d      = 1'b0;
          addr_d    = '0;
          din_d     = '0;
          state_d   = StDone;
        end
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= StIdle;
      run_cnt_q  <= '0;
      timer_q    <= '0;
      stb_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      din_q      <= '0;
      owner_q    <= OwnNone;
      vid_ack_q  <= 1'b0;
      cmd_ack_q  <= 1'b0;
      err_q      <= 1'b0;
      vid_data_q <= '0;
      cmd_data_q <= '0;
    end else begin
      state_q    <= state_d;
      run_cnt_q  <= run_cnt_d;
      timer_q    <= timer_d;
      stb_q      <= stb_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      din_q      <= din_d;
      owner_q    <= owner_d;
      vid_ack_q  <= vid_ack_d;
      cmd_ack_q  <= cmd_ack_d;
      err_q      <= err_d;
      vid_data_q <= vid_data_d;
      cmd_data_q <= cmd_data_d;
    end
  end

  assign o_stb      = stb_q;
  assign o_we       = we_q;
  assign o_addr     = addr_q;
  assign o_din      = din_q;
  assign o_owner    = owner_q;
  assign o_vid_ack  = vid_ack_q;
  assign o_cmd_ack  = cmd_ack_q;
  assign o_err      = err_q;
  assign o_vid_data = vid_data_q;
  assign o_cmd_data = cmd_data_q;

endmodule
